control_unit: RTL and testbench
===============================

# control_unit

Instruction-sequencing FSM for the processor datapath. It owns the instruction register and drives the program counter's `Clr`/`Up` controls. It decodes each 16-bit instruction into data-memory, register-file and ALU control signals. It sits between the PC/instruction ROM on one side and the data RAM, register file and ALU on the other.

## Interface
Parameters:
- `IW`, default 16: instruction width.
- `DAW`, default 8: data-memory address width.
- `RAW`, default 4: register-file address width.

Ports:
- `Clk` in, 1: sole clock, rising edge.
- `ClrN` in, 1: asynchronous, active-low reset.
- `Instr` in, IW: instruction-ROM output at the current PC address.
- `PC_clr` out, 1: drives PC `Clr`, active high.
- `PC_up` out, 1: drives PC `Up`.
- `IR_ld` out, 1: instruction-register load strobe, exported for debug.
- `D_addr` out, DAW: data-memory address.
- `D_wr` out, 1: data-memory write enable.
- `RF_s` out, 1: register-file write mux select; 1 = data memory, 0 = ALU.
- `RF_W_addr` out, RAW: register-file write address.
- `RF_W_en` out, 1: register-file write enable.
- `RF_Ra_addr`, `RF_Rb_addr` out, RAW each: register-file read addresses.
- `ALU_s0` out, 3: ALU function select.
- `CurState` out, 4: state encoding, for the hex display.

## Operation
Opcode is `IR[15:12]`:
- NOOP 0000.
- STORE 0001: Ra = `IR[11:8]`, addr = `IR[7:0]`.
- LOAD 0010: addr = `IR[11:4]`, Rd = `IR[3:0]`.
- ADD 0011 and SUB 0100: Ra = `IR[11:8]`, Rb = `IR[7:4]`, Rd = `IR[3:0]`.
- HALT 0101.
- Opcodes 0110–1111 are illegal.

States and `CurState` codes:
- Init=0: `PC_clr`=1; next state Fetch.
- Fetch=1: `IR_ld`=1, `PC_up`=1; IR captures `Instr`; next state Decode.
- Decode=2: branch on opcode to Noop, Store, LoadA, Add, Sub or Halt.
- Noop=3: next state Fetch.
- LoadA=4: `D_addr`=`IR[11:4]`, `RF_s`=1, `RF_W_addr`=`IR[3:0]`; next state LoadB.
- LoadB=5: same outputs as LoadA plus `RF_W_en`=1; next state Fetch.
- Store=6: `D_addr`=`IR[7:0]`, `RF_Ra_addr`=`IR[11:8]`, `D_wr`=1; next state Fetch.
- Add=7: Ra/Rb/Rd from IR, `ALU_s0`=001, `RF_s`=0, `RF_W_en`=1; next state Fetch.
- Sub=8: as Add with `ALU_s0`=010.
- Halt=9: remains in Halt; only `ClrN` exits.

Output rules:
- All outputs are Moore: a function of state and IR only, never of `Instr` directly.
- Any output not listed for a state is 0.

## Timing
- Reset: `ClrN` low forces state Init and IR = 0 immediately, without waiting for a clock edge.
- While in reset: `PC_clr`=1, all other outputs 0, `CurState`=0.
- After `ClrN` rises: Init holds for one cycle, then Fetch follows.
- ROM contract: `Instr` is valid during Fetch, i.e. one cycle after the PC address settles. The controller adds no wait states.
- Instruction latency: NOOP, STORE, ADD and SUB take 3 cycles (Fetch, Decode, exec). LOAD takes 4 cycles.
- LoadA exists to cover the one-cycle synchronous RAM read. `RF_W_en` is asserted in LoadB only.
- `D_wr` and `RF_W_en` are each high for exactly one cycle per instruction.
- PC wrap from 127 to 0 is native to the PC. The controller takes no action on it.
- Reset mid-instruction: `D_wr` and `RF_W_en` drop to 0 asynchronously and no partial write is committed after the reset edge.
- `PC_up` is never asserted outside Fetch.

## Configuration
Macro `CU_ILLEGAL_TRAP_EN`:
- Defined:
  - Illegal opcodes branch from Decode to Halt.
  - An extra output port `Illegal` (out, 1) is present. It is set on the Decode→Halt transition for an illegal opcode and stays set until `ClrN` is asserted.
  - `Illegal` resets to 0.
- Undefined:
  - Illegal opcodes execute as NOOP.
  - The `Illegal` port is absent.

## Structure
Package `cu_pkg` holds:
- The state enum with the explicit 4-bit codes listed under Operation.
- The opcode enum.
- ALU select constants: `ALU_ADD`=3'b001, `ALU_SUB`=3'b010, `ALU_ZERO`=3'b000.

Sub-module `instruction_register` (parameter IW):
- Ports: `Clk`, `ClrN`, `Ld`, `D`, `Q`.
- Asynchronous clear to 0; loads `D` on the clock edge when `Ld`=1.
- `control_unit` instantiates it.

The state register, next-state logic and output decode are three separate processes inside `control_unit`.

## Test plan
- Reset: pulse `ClrN` low mid-cycle → `CurState`=0 and `PC_clr`=1 immediately. After release, Fetch is entered in cycle 1 with `PC_up`=`IR_ld`=1, and Decode in cycle 2.
- ADD: `Instr`=16'h3215 → in Add, `RF_Ra_addr`=2, `RF_Rb_addr`=1, `RF_W_addr`=5, `ALU_s0`=001, `RF_W_en`=1 for one cycle; Fetch is re-entered 3 cycles after the previous Fetch. SUB 16'h4215 gives the same with `ALU_s0`=010.
- LOAD: `Instr`=16'h21B3 → `D_addr`=8'h1B, `RF_s`=1 and `RF_W_addr`=3 in both LoadA and LoadB; `RF_W_en` is 0 in LoadA and 1 in LoadB. Repeat with `ClrN` dropped during LoadB → `RF_W_en` falls without a clock edge.
- STORE: `Instr`=16'h1A40 → `D_addr`=8'h40, `RF_Ra_addr`=10, `D_wr`=1 for exactly one cycle, `RF_W_en`=0 throughout.
- HALT: `Instr`=16'h5000 → `CurState`=9 for 20 or more cycles, `PC_up` stays 0 and no write enables assert; only `ClrN` low recovers.
- Illegal: `Instr`=16'hF000 → with `CU_ILLEGAL_TRAP_EN`, Halt is entered and `Illegal`=1 until reset; without it, the Noop path runs and Fetch follows 3 cycles later.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types for the instruction-sequencing controller: state codes,
// opcodes and ALU function selects.
package cu_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5
    } opcode_t;

    localparam logic [2:0] ALU_ZERO = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/instruction_register.sv
// Instruction register: asynchronous clear, loads D on the clock edge when Ld is high.
module instruction_register #(
    parameter int IW = 16
) (
    input  logic          Clk,
    input  logic          ClrN,
    input  logic          Ld,
    input  logic [IW-1:0] D,
    output logic [IW-1:0] Q
);

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN)
            Q <= '0;
        else if (Ld)
            Q <= D;
    end

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing FSM: fetches into the IR, decodes and drives memory/RF/ALU controls.
// Build option CU_ILLEGAL_TRAP_EN: illegal opcodes trap to Halt and set the Illegal flag.
//
// state  | meaning
// Init   | PC cleared, waiting one cycle after reset
// Fetch  | IR loads Instr, PC increments
// Decode | branch on IR opcode
// Noop   | no operation
// LoadA  | data RAM read in flight
// LoadB  | RAM data written into register file
// Store  | register Ra written to data RAM
// Add    | Rd = Ra + Rb
// Sub    | Rd = Ra - Rb
// Halt   | stuck until reset
module control_unit
    import cu_pkg::*;
#(
    parameter int IW  = 16,
    parameter int DAW = 8,
    parameter int RAW = 4
) (
    input  logic           Clk,
    input  logic           ClrN,
    input  logic [IW-1:0]  Instr,
    output logic           PC_clr,
    output logic           PC_up,
    output logic           IR_ld,
    output logic [DAW-1:0] D_addr,
    output logic           D_wr,
    output logic           RF_s,
    output logic [RAW-1:0] RF_W_addr,
    output logic           RF_W_en,
    output logic [RAW-1:0] RF_Ra_addr,
    output logic [RAW-1:0] RF_Rb_addr,
    output logic [2:0]     ALU_s0,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic           Illegal,
`endif
    output logic [3:0]     CurState
);

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] ir_q;
    logic [3:0]    opcode;

    assign opcode   = ir_q[15:12];
    assign CurState = state_q;

    instruction_register #(.IW(IW)) u_ir (
        .Clk  (Clk),
        .ClrN (ClrN),
        .Ld   (IR_ld),
        .D    (Instr),
        .Q    (ir_q)
    );

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN)
            state_q <= S_INIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_NOOP:  state_d = S_NOOP;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOADA;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
                    default:  state_d = S_HALT;
`else
                    default:  state_d = S_NOOP;
`endif
                endcase
            end
            S_LOADA:  state_d = S_LOADB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = ALU_ZERO;
        case (state_q)
            S_INIT:  PC_clr = 1'b1;
            S_FETCH: begin
                IR_ld = 1'b1;
                PC_up = 1'b1;
            end
            S_LOADA, S_LOADB: begin
                D_addr    = ir_q[11:4];
                RF_s      = 1'b1;
                RF_W_addr = ir_q[3:0];
                RF_W_en   = (state_q == S_LOADB);
            end
            S_STORE: begin
                D_addr     = ir_q[7:0];
                RF_Ra_addr = ir_q[11:8];
                D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = ir_q[11:8];
                RF_Rb_addr = ir_q[7:4];
                RF_W_addr  = ir_q[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

`ifdef CU_ILLEGAL_TRAP_EN
    // Sticky flag: only reset clears it, so the trap cause survives in Halt.
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN)
            Illegal <= 1'b0;
        else if (state_q == S_DECODE && opcode > OP_HALT)
            Illegal <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; also builds with CU_ILLEGAL_TRAP_EN defined.
module tb_control_unit;

    logic        Clk = 1'b0;
    logic        ClrN;
    logic [15:0] Instr;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, CurState;
    logic [2:0]  ALU_s0;
`ifdef CU_ILLEGAL_TRAP_EN
    logic        Illegal;
`endif

    int n_chk = 0;
    int n_bad = 0;

    control_unit dut (
        .Clk        (Clk),
        .ClrN       (ClrN),
        .Instr      (Instr),
        .PC_clr     (PC_clr),
        .PC_up      (PC_up),
        .IR_ld      (IR_ld),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
`ifdef CU_ILLEGAL_TRAP_EN
        .Illegal    (Illegal),
`endif
        .CurState   (CurState)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Called while in Fetch: present the instruction, then advance into Decode.
    task automatic fetch(input logic [15:0] ins);
        chk("fetch_state", CurState, 4'd1);
        chk("fetch_pc_up", PC_up, 1'b1);
        chk("fetch_ir_ld", IR_ld, 1'b1);
        Instr = ins;
        step();
        chk("decode_state", CurState, 4'd2);
        chk("decode_pc_up", PC_up, 1'b0);
    endtask

    task automatic reset_to_fetch();
        @(negedge Clk);
        ClrN = 1'b0;
        #1;
        chk("rst_state", CurState, 4'd0);
        chk("rst_pc_clr", PC_clr, 1'b1);
        @(negedge Clk);
        ClrN = 1'b1;
        step();
    endtask

    initial begin
        ClrN  = 1'b0;
        Instr = 16'h0000;
        #12;
        chk("por_state", CurState, 4'd0);
        chk("por_pc_clr", PC_clr, 1'b1);
        chk("por_pc_up", PC_up, 1'b0);
        chk("por_ir_ld", IR_ld, 1'b0);
        chk("por_rf_w_en", RF_W_en, 1'b0);
        @(negedge Clk);
        ClrN = 1'b1;
        step();
        chk("cyc1_pc_clr", PC_clr, 1'b0);

        // ADD 3215
        fetch(16'h3215);
        step();
        chk("add_state", CurState, 4'd7);
        chk("add_ra", RF_Ra_addr, 4'd2);
        chk("add_rb", RF_Rb_addr, 4'd1);
        chk("add_rd", RF_W_addr, 4'd5);
        chk("add_alu", ALU_s0, 3'b001);
        chk("add_rf_s", RF_s, 1'b0);
        chk("add_wen", RF_W_en, 1'b1);
        step();
        chk("add_wen_off", RF_W_en, 1'b0);

        // SUB 4215
        fetch(16'h4215);
        step();
        chk("sub_state", CurState, 4'd8);
        chk("sub_ra", RF_Ra_addr, 4'd2);
        chk("sub_rb", RF_Rb_addr, 4'd1);
        chk("sub_rd", RF_W_addr, 4'd5);
        chk("sub_alu", ALU_s0, 3'b010);
        chk("sub_wen", RF_W_en, 1'b1);
        step();

        // LOAD 21B3
        fetch(16'h21B3);
        step();
        chk("lda_state", CurState, 4'd4);
        chk("lda_addr", D_addr, 8'h1B);
        chk("lda_rf_s", RF_s, 1'b1);
        chk("lda_rd", RF_W_addr, 4'd3);
        chk("lda_wen", RF_W_en, 1'b0);
        step();
        chk("ldb_state", CurState, 4'd5);
        chk("ldb_addr", D_addr, 8'h1B);
        chk("ldb_rf_s", RF_s, 1'b1);
        chk("ldb_rd", RF_W_addr, 4'd3);
        chk("ldb_wen", RF_W_en, 1'b1);
        step();

        // STORE 1A40
        fetch(16'h1A40);
        chk("decode_dwr", D_wr, 1'b0);
        step();
        chk("st_state", CurState, 4'd6);
        chk("st_addr", D_addr, 8'h40);
        chk("st_ra", RF_Ra_addr, 4'd10);
        chk("st_dwr", D_wr, 1'b1);
        chk("st_wen", RF_W_en, 1'b0);
        step();
        chk("st_dwr_off", D_wr, 1'b0);

        // Illegal F000
        fetch(16'hF000);
        step();
`ifdef CU_ILLEGAL_TRAP_EN
        chk("ill_state", CurState, 4'd9);
        chk("ill_flag", Illegal, 1'b1);
        step();
        chk("ill_flag_hold", Illegal, 1'b1);
        reset_to_fetch();
        chk("ill_flag_clr", Illegal, 1'b0);
`else
        chk("ill_noop_state", CurState, 4'd3);
        step();
`endif

        // LOAD with reset dropped mid-LoadB
        fetch(16'h21B3);
        step();
        step();
        chk("ldb2_wen", RF_W_en, 1'b1);
        #2;
        ClrN = 1'b0;
        #1;
        chk("async_wen", RF_W_en, 1'b0);
        chk("async_state", CurState, 4'd0);
        chk("async_pc_clr", PC_clr, 1'b1);
        chk("async_daddr", D_addr, 8'h00);
        step();
        chk("inrst_state", CurState, 4'd0);
        @(negedge Clk);
        ClrN = 1'b1;
        step();

        // HALT 5000
        fetch(16'h5000);
        begin
            int halt_err;
            halt_err = 0;
            for (int i = 0; i < 22; i++) begin
                step();
                if (CurState !== 4'd9 || PC_up !== 1'b0 || D_wr !== 1'b0 || RF_W_en !== 1'b0)
                    halt_err++;
            end
            chk("halt_cycles_bad", halt_err, 0);
        end
        chk("halt_state", CurState, 4'd9);
        reset_to_fetch();
        chk("recover_state", CurState, 4'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
